eth_tx_frame_arb: RTL and testbench

ETH_TX_FRAME_ARB -- requirements
Module: eth_tx_frame_arb

---
 rtl/eth_tx_frame_arb_pkg.sv | 28 ++
 rtl/eth_tx_frame_arb_rr_arb_select.sv | 35 +++
 rtl/eth_tx_frame_arb.sv | 189 ++++++++++++++++++
 tb/tb_eth_tx_frame_arb.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_frame_arb_pkg.sv
// Shared definitions for the Ethernet TX frame arbiter.
//
// Contents:
//   MAC_W, TYPE_W - widths of the Ethernet header fields.
//   MAX_PORTS     - largest supported requester count.
//   PORT_IDX_W    - width of a requester index.
//   onehot_to_idx - converts a one-hot requester vector into its index.
package eth_tx_frame_arb_pkg;

  localparam int MAC_W      = 48;
  localparam int TYPE_W     = 16;
  localparam int MAX_PORTS  = 8;
  localparam int PORT_IDX_W = 3;

  // Returns the index of the set bit. Callers pass a one-hot or all-zero
  // vector; all-zero yields index 0.
  function automatic logic [PORT_IDX_W-1:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
    logic [PORT_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) begin
        idx = idx | PORT_IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/eth_tx_frame_arb_rr_arb_select.sv
// Round-robin requester selection, purely combinational.
//
// Ports:
//   req_i        - request vector, one bit per requester.
//   last_grant_i - index of the requester that owned the previous frame.
//   grant_o      - one-hot winner; all zero when nothing is requesting.
//
// The search starts at (last_grant_i + 1) mod S_COUNT and wraps, so the
// previous owner has the lowest priority in the next round.
module rr_arb_select
  import eth_tx_frame_arb_pkg::*;
#(
  parameter int S_COUNT = 2
) (
  input  logic [S_COUNT-1:0]    req_i,
  input  logic [PORT_IDX_W-1:0] last_grant_i,
  output logic [S_COUNT-1:0]    grant_o
);

  always_comb begin : sel_p
    int   idx;
    logic found;
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 1; i <= S_COUNT; i++) begin
      idx = (int'(last_grant_i) + i) % S_COUNT;
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_frame_arb.sv
// Ethernet TX frame arbiter: multiplexes S_COUNT header+payload frame
// sources onto one eth_axis_tx style output, one whole frame at a time.
//
// Ports:
//   clk, rst                    - clock, synchronous active-high reset.
//   s_eth_hdr_valid/_ready      - per-requester header handshake.
//   s_eth_dest_mac/_src_mac     - flattened 48-bit MACs, port i at [i*48 +: 48].
//   s_eth_type                  - flattened 16-bit EtherType.
//   s_eth_payload_axis_*        - flattened per-requester payload stream.
//   m_eth_hdr_valid/_ready      - output header handshake.
//   m_eth_dest_mac/_src_mac/_type - output header fields.
//   m_eth_payload_axis_*        - output payload stream.
//   grant                       - one-hot current owner, zero when idle.
//   busy                        - a frame is owned (header or payload phase).
//   frame_count                 - frames completed, wraps at 2^32.
module eth_tx_frame_arb
  import eth_tx_frame_arb_pkg::*;
#(
  parameter int S_COUNT    = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic [S_COUNT-1:0]            s_eth_hdr_valid,
  output logic [S_COUNT-1:0]            s_eth_hdr_ready,
  input  logic [S_COUNT*MAC_W-1:0]      s_eth_dest_mac,
  input  logic [S_COUNT*MAC_W-1:0]      s_eth_src_mac,
  input  logic [S_COUNT*TYPE_W-1:0]     s_eth_type,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic [S_COUNT-1:0]            s_eth_payload_axis_tvalid,
  output logic [S_COUNT-1:0]            s_eth_payload_axis_tready,
  input  logic [S_COUNT-1:0]            s_eth_payload_axis_tlast,
  input  logic [S_COUNT-1:0]            s_eth_payload_axis_tuser,

  output logic                          m_eth_hdr_valid,
  input  logic                          m_eth_hdr_ready,
  output logic [MAC_W-1:0]              m_eth_dest_mac,
  output logic [MAC_W-1:0]              m_eth_src_mac,
  output logic [TYPE_W-1:0]             m_eth_type,
  output logic [DATA_WIDTH-1:0]         m_eth_payload_axis_tdata,
  output logic                          m_eth_payload_axis_tvalid,
  input  logic                          m_eth_payload_axis_tready,
  output logic                          m_eth_payload_axis_tlast,
  output logic                          m_eth_payload_axis_tuser,

  output logic [S_COUNT-1:0]            grant,
  output logic                          busy,
  output logic [31:0]                   frame_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [S_COUNT-1:0]      grant_q, grant_d;
  logic [PORT_IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [31:0]             frame_count_q, frame_count_d;

  logic [S_COUNT-1:0]      sel_grant;
  logic [MAX_PORTS-1:0]    grant_ext;
  logic [PORT_IDX_W-1:0]   grant_idx;

  // Fields of the granted port. grant_q is one-hot (or zero), so an AND-OR
  // mux is an exact select and yields zeros when nothing is granted.
  logic                    hdr_valid_sel;
  logic [MAC_W-1:0]        dest_sel;
  logic [MAC_W-1:0]        src_sel;
  logic [TYPE_W-1:0]       type_sel;
  logic [DATA_WIDTH-1:0]   tdata_sel;
  logic                    tvalid_sel;
  logic                    tlast_sel;
  logic                    tuser_sel;
  logic                    last_beat;

  rr_arb_select #(
    .S_COUNT(S_COUNT)
  ) u_rr_arb_select (
    .req_i       (s_eth_hdr_valid),
    .last_grant_i(last_grant_q),
    .grant_o     (sel_grant)
  );

  always_comb begin
    grant_ext                = '0;
    grant_ext[S_COUNT-1:0]   = grant_q;
  end

  assign grant_idx = onehot_to_idx(grant_ext);

  always_comb begin
    hdr_valid_sel = 1'b0;
    dest_sel      = '0;
    src_sel       = '0;
    type_sel      = '0;
    tdata_sel     = '0;
    tvalid_sel    = 1'b0;
    tlast_sel     = 1'b0;
    tuser_sel     = 1'b0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_q[i]) begin
        hdr_valid_sel = hdr_valid_sel | s_eth_hdr_valid[i];
        dest_sel      = dest_sel  | s_eth_dest_mac[i*MAC_W +: MAC_W];
        src_sel       = src_sel   | s_eth_src_mac[i*MAC_W +: MAC_W];
        type_sel      = type_sel  | s_eth_type[i*TYPE_W +: TYPE_W];
        tdata_sel     = tdata_sel | s_eth_payload_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        tvalid_sel    = tvalid_sel | s_eth_payload_axis_tvalid[i];
        tlast_sel     = tlast_sel  | s_eth_payload_axis_tlast[i];
        tuser_sel     = tuser_sel  | s_eth_payload_axis_tuser[i];
      end
    end
  end

  // Readies reach only the owner, and only in the phase that owns the
  // matching channel; everyone else sees zero.
  for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_ready
    assign s_eth_hdr_ready[gi]           = (state_q == HDR) && grant_q[gi] && m_eth_hdr_ready;
    assign s_eth_payload_axis_tready[gi] = (state_q == PAYLOAD) && grant_q[gi] && m_eth_payload_axis_tready;
  end

  assign last_beat = tvalid_sel && m_eth_payload_axis_tready && tlast_sel;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    frame_count_d = frame_count_q;

    m_eth_hdr_valid           = 1'b0;
    m_eth_payload_axis_tvalid = 1'b0;
    m_eth_dest_mac            = dest_sel;
    m_eth_src_mac             = src_sel;
    m_eth_type                = type_sel;
    m_eth_payload_axis_tdata  = tdata_sel;
    m_eth_payload_axis_tlast  = tlast_sel;
    m_eth_payload_axis_tuser  = tuser_sel;

    case (state_q)
      IDLE: begin
        if (|s_eth_hdr_valid) begin
          grant_d = sel_grant;
          state_d = HDR;
        end
      end
      HDR: begin
        m_eth_hdr_valid = hdr_valid_sel;
        if (hdr_valid_sel && m_eth_hdr_ready) begin
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        m_eth_payload_axis_tvalid = tvalid_sel;
        if (last_beat) begin
          frame_count_d = frame_count_q + 32'd1;
          last_grant_d  = grant_idx;
          grant_d       = '0;
          state_d       = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      // Previous owner = last port, so port 0 wins the first round.
      last_grant_q  <= PORT_IDX_W'(S_COUNT - 1);
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_eth_tx_frame_arb.sv
// Testbench for eth_tx_frame_arb: a cycle-based frame source per port, a
// monitor on the output side, and header/beat scoreboards filled when
// frames are queued.
module tb_eth_tx_frame_arb;

  localparam int S  = 2;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [S-1:0]      s_hdr_valid, s_hdr_ready;
  logic [S*48-1:0]   s_dest, s_src;
  logic [S*16-1:0]   s_type;
  logic [S*DW-1:0]   s_tdata;
  logic [S-1:0]      s_tvalid, s_tready, s_tlast, s_tuser;
  logic              m_hdr_valid, m_hdr_ready;
  logic [47:0]       m_dest, m_src;
  logic [15:0]       m_type;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid, m_tready, m_tlast, m_tuser;
  logic [S-1:0]      grant;
  logic              busy;
  logic [31:0]       frame_count;

  always #5 clk = ~clk;

  eth_tx_frame_arb #(.S_COUNT(S), .DATA_WIDTH(DW)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .s_eth_hdr_valid          (s_hdr_valid),
    .s_eth_hdr_ready          (s_hdr_ready),
    .s_eth_dest_mac           (s_dest),
    .s_eth_src_mac            (s_src),
    .s_eth_type               (s_type),
    .s_eth_payload_axis_tdata (s_tdata),
    .s_eth_payload_axis_tvalid(s_tvalid),
    .s_eth_payload_axis_tready(s_tready),
    .s_eth_payload_axis_tlast (s_tlast),
    .s_eth_payload_axis_tuser (s_tuser),
    .m_eth_hdr_valid          (m_hdr_valid),
    .m_eth_hdr_ready          (m_hdr_ready),
    .m_eth_dest_mac           (m_dest),
    .m_eth_src_mac            (m_src),
    .m_eth_type               (m_type),
    .m_eth_payload_axis_tdata (m_tdata),
    .m_eth_payload_axis_tvalid(m_tvalid),
    .m_eth_payload_axis_tready(m_tready),
    .m_eth_payload_axis_tlast (m_tlast),
    .m_eth_payload_axis_tuser (m_tuser),
    .grant                    (grant),
    .busy                     (busy),
    .frame_count              (frame_count)
  );

  typedef struct { int port; int len; bit user; int tag; } frame_t;
  typedef struct { logic [7:0] data; bit last; bit user; int port; } beat_t;
  typedef struct { int port; logic [47:0] dest; logic [47:0] src; logic [15:0] etype; } hdr_t;

  frame_t src_q[$];
  beat_t  beat_q[$];
  hdr_t   hdr_q[$];

  int     n_checks = 0;
  int     n_errors = 0;
  int     phase[S];
  int     beat[S];
  frame_t cur[S];
  bit     tready_toggle = 1'b0;
  bit     sb_en = 1'b1;
  int     beat_seen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int tag, input int k);
    return 8'((tag * 29 + k * 3 + 1) & 255);
  endfunction

  function automatic logic [47:0] dest_of(input int port, input int tag);
    return {16'h0200, 8'(port), 8'(tag), 16'hbeef};
  endfunction

  function automatic logic [47:0] src_of(input int tag);
    return {24'h0a0b0c, 24'(tag)};
  endfunction

  function automatic logic [15:0] type_of(input int tag);
    return 16'h0800 + 16'(tag);
  endfunction

  // Reference round-robin: first requester after the previous owner.
  function automatic logic [S-1:0] rr_model(input logic [S-1:0] req, input int last);
    logic [S-1:0] one;
    one = 1;
    for (int k = 1; k <= S; k++) begin
      int idx;
      idx = (last + k) % S;
      if (req[idx]) return one << idx;
    end
    return '0;
  endfunction

  task automatic queue_frame(input int port, input int len, input bit user, input int tag,
                             input bit expect_out);
    frame_t f;
    hdr_t   h;
    beat_t  b;
    f.port = port; f.len = len; f.user = user; f.tag = tag;
    src_q.push_back(f);
    if (expect_out) begin
      h.port = port; h.dest = dest_of(port, tag); h.src = src_of(tag); h.etype = type_of(tag);
      hdr_q.push_back(h);
      for (int k = 0; k < len; k++) begin
        b.data = byte_of(tag, k);
        b.last = (k == len - 1);
        b.user = (k == len - 1) && user;
        b.port = port;
        beat_q.push_back(b);
      end
    end
  endtask

  // Source side: handshakes are sampled on the falling edge and state is
  // advanced just after the rising edge that completed them.
  initial begin
    bit           abandon;
    logic [S-1:0] hs_h, hs_p;
    s_hdr_valid = '0; s_dest = '0; s_src = '0; s_type = '0;
    s_tdata = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
    m_hdr_ready = 1'b1; m_tready = 1'b1;
    for (int p = 0; p < S; p++) begin phase[p] = 0; beat[p] = 0; end
    forever begin
      @(negedge clk);
      hs_h    = s_hdr_valid & s_hdr_ready;
      hs_p    = s_tvalid & s_tready;
      abandon = rst;
      @(posedge clk); #1;
      for (int p = 0; p < S; p++) begin
        if (abandon) begin
          phase[p] = 0;
        end else if (phase[p] == 1 && hs_h[p]) begin
          phase[p] = 2; beat[p] = 0;
        end else if (phase[p] == 2 && hs_p[p]) begin
          if (beat[p] == cur[p].len - 1) phase[p] = 0;
          else beat[p]++;
        end
        if (phase[p] == 0) begin
          for (int i = 0; i < src_q.size(); i++) begin
            if (src_q[i].port == p) begin
              cur[p] = src_q[i];
              src_q.delete(i);
              phase[p] = 1;
              break;
            end
          end
        end
        s_hdr_valid[p]       = (phase[p] == 1);
        s_dest[p*48 +: 48]   = (phase[p] != 0) ? dest_of(p, cur[p].tag) : 48'h0;
        s_src[p*48 +: 48]    = (phase[p] != 0) ? src_of(cur[p].tag) : 48'h0;
        s_type[p*16 +: 16]   = (phase[p] != 0) ? type_of(cur[p].tag) : 16'h0;
        s_tvalid[p]          = (phase[p] == 2);
        s_tdata[p*DW +: DW]  = (phase[p] == 2) ? byte_of(cur[p].tag, beat[p]) : 8'h00;
        s_tlast[p]           = (phase[p] == 2) && (beat[p] == cur[p].len - 1);
        s_tuser[p]           = (phase[p] == 2) && (beat[p] == cur[p].len - 1) && cur[p].user;
      end
      m_tready = tready_toggle ? ~m_tready : 1'b1;
    end
  end

  // Output monitor.
  initial begin
    int           cyc, tlast_cyc, model_last;
    bit           arm, gap_pend, gap_exp;
    logic [S-1:0] arm_grant;
    hdr_t         h;
    beat_t        b;
    cyc = 0; tlast_cyc = 0; model_last = S - 1;
    arm = 0; gap_pend = 0; gap_exp = 0; arm_grant = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        arm = 0; gap_pend = 0; model_last = S - 1;
        continue;
      end
      if (arm) begin
        check("hdr_latency_grant", {m_hdr_valid, grant}, {1'b1, arm_grant});
        arm = 0;
      end
      if (!busy) begin
        check("idle_readies", {s_hdr_ready, s_tready}, '0);
        if (|s_hdr_valid) begin
          arm = 1;
          arm_grant = rr_model(s_hdr_valid, model_last);
        end
      end
      if (gap_pend && m_hdr_valid) begin
        gap_pend = 0;
        if (gap_exp) check("idle_gap", 64'(cyc - tlast_cyc), 64'd2);
      end
      if (m_hdr_valid && m_hdr_ready && sb_en) begin
        if (hdr_q.size() == 0) begin
          check("hdr_unexpected", 64'd1, 64'd0);
        end else begin
          h = hdr_q.pop_front();
          check("hdr_grant", grant, 64'(1) << h.port);
          check("hdr_dest", m_dest, h.dest);
          check("hdr_src", m_src, h.src);
          check("hdr_type", m_type, h.etype);
        end
      end
      if (m_tvalid && m_tready) begin
        beat_seen++;
        if (sb_en) begin
          if (beat_q.size() == 0) begin
            check("beat_unexpected", 64'd1, 64'd0);
          end else begin
            b = beat_q.pop_front();
            check("beat_data", m_tdata, b.data);
            check("beat_last", m_tlast, b.last);
            check("beat_user", m_tuser, b.user);
            if (b.last) begin
              model_last = b.port;
              tlast_cyc  = cyc;
              gap_pend   = 1;
              gap_exp    = (src_q.size() != 0);
              for (int p = 0; p < S; p++) if (phase[p] == 1) gap_exp = 1;
              $display("frame done: port %0d tuser %0d at cycle %0d", b.port, b.user, cyc);
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    src_q.delete(); hdr_q.delete(); beat_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((hdr_q.size() != 0 || beat_q.size() != 0 || src_q.size() != 0) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 64'(hdr_q.size() + beat_q.size() + src_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int target, input int limit);
    int n;
    n = 0;
    while (beat_seen < target && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check("beats_reached", 64'(beat_seen >= target), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant, '0);
    check("rst_frame_count", frame_count, 32'd0);
    check("rst_out_valids", {m_hdr_valid, m_tvalid}, '0);

    // Single 64-byte frame from port 0.
    queue_frame(0, 64, 1'b0, 1, 1'b1);
    wait_drain(2000);
    check("t1_frame_count", frame_count, 32'd1);

    // Both ports continuously requesting, 4 frames each: alternate 0,1,...
    do_reset();
    for (int k = 0; k < 4; k++) begin
      queue_frame(0, 8 + k, 1'b0, 10 + k, 1'b1);
      queue_frame(1, 5 + k, 1'b0, 20 + k, 1'b1);
    end
    wait_drain(3000);
    check("t2_frame_count", frame_count, 32'd8);

    // Port 1 arrives during port 0's payload.
    do_reset();
    beat_seen = 0;
    queue_frame(0, 16, 1'b0, 30, 1'b1);
    wait_beats(5, 500);
    queue_frame(1, 6, 1'b0, 31, 1'b1);
    wait_drain(2000);
    check("t3_frame_count", frame_count, 32'd2);

    // Output payload ready toggling every cycle.
    do_reset();
    tready_toggle = 1'b1;
    queue_frame(0, 20, 1'b0, 40, 1'b1);
    queue_frame(1, 12, 1'b0, 41, 1'b1);
    wait_drain(3000);
    tready_toggle = 1'b0;
    check("t4_frame_count", frame_count, 32'd2);

    // Lone requester, back-to-back frames.
    do_reset();
    for (int k = 0; k < 3; k++) queue_frame(1, 4, 1'b0, 50 + k, 1'b1);
    wait_drain(2000);
    check("t5_frame_count", frame_count, 32'd3);

    // Reset on beat 20 of a frame, then a request on port 1 only.
    do_reset();
    sb_en = 1'b0;
    beat_seen = 0;
    queue_frame(0, 40, 1'b0, 60, 1'b0);
    wait_beats(20, 500);
    rst = 1'b1;
    src_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_busy", busy, 1'b0);
    check("t6_grant", grant, '0);
    check("t6_frame_count", frame_count, 32'd0);
    check("t6_out_valids", {m_hdr_valid, m_tvalid}, '0);
    check("t6_readies", {s_hdr_ready, s_tready}, '0);
    sb_en = 1'b1;
    queue_frame(1, 10, 1'b0, 61, 1'b1);
    wait_drain(2000);
    check("t6_frame_count_after", frame_count, 32'd1);

    // Errored frame (tuser on tlast) from port 1 still completes and counts.
    do_reset();
    queue_frame(0, 3, 1'b0, 70, 1'b1);
    queue_frame(1, 7, 1'b1, 71, 1'b1);
    wait_drain(2000);
    check("t7_frame_count", frame_count, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
